sha256_msg_sched: RTL
=====================

Name: sha256_msg_sched

Overview:
- Sequencer for the SHA-256 message-schedule datapath: the rotate/shift sigma functions plus a 32-bit adder.
- Accepts one 512-bit block as 16 big-endian 32-bit words over a valid/ready input.
- Emits the 64 schedule words W[0..63] in order over a valid/ready output, one per cycle when not stalled.
- Sits between the block padder and the compression-round engine; owns the 16-entry circular word buffer.

Parameters:
- WORDS, 16, words per input block and circular-buffer depth; fixed at 16 for SHA-256, not to be overridden.
- ROUNDS, 64, schedule words emitted per block.

Ports:
- clk  input  1  single clock; all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  in_word valid
- in_ready  output  1  block can accept a word this cycle
- in_word  input  32  message word; M[0] first
- wt_valid  output  1  wt holds a valid schedule word
- wt_ready  input  1  consumer accepts wt
- wt  output  32  schedule word W[t]
- wt_idx  output  6  t of the word on wt
- busy  output  1  high in LOAD or RUN
- done  output  1  one-cycle pulse after W[63] handshake

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE; in_ready=0; wt_valid=0; wt=0; wt_idx=0; busy=0; done=0; load and t counters 0. Buffer contents are don't-care.
- sigma0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
- sigma1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
- All adds are modulo 2^32; carries are discarded.
- IDLE state:
  - in_ready=1, busy=0.
  - On an in_valid&&in_ready beat: write buf[0], load count=1, go to LOAD.
- LOAD state:
  - in_ready=1, busy=1.
  - Each beat writes buf[count] and increments count.
  - On the beat with count==15, go to RUN with t=0.
  - Gaps in in_valid are allowed; count holds.
- RUN state:
  - in_ready=0, busy=1.
  - Output register loads when !wt_valid || wt_ready.
  - For t<16: wt <= buf[t].
  - For t>=16, with slot index i = t mod 16:
    - wt <= sigma1(buf[(t-2)%16]) + buf[(t-7)%16] + sigma0(buf[(t-15)%16]) + buf[t%16]
    - buf[t%16] is overwritten with the same value in the same cycle.
  - On each load, wt_idx <= t, t increments, and wt_valid=1.
  - First wt_valid is the cycle after the 16th input beat (latency 1).
  - Throughput is 1 word/cycle while wt_ready=1.
  - When wt_valid&&!wt_ready: wt, wt_idx, t and buffer all hold.
  - When the handshake on wt_idx==63 fires: wt_valid=0, done pulses the next cycle, state returns to IDLE.
  - No new W is computed after t reaches 64.
- Boundary cases:
  - wt_ready asserted while wt_valid=0 has no effect.
  - in_valid during RUN is ignored (in_ready=0); no buffer write.
  - Back-to-back blocks: a new block may start loading the cycle after done.
  - rst_n asserted mid-LOAD or mid-RUN aborts immediately to reset values; the partial block is lost.
  - t wraps only via return to IDLE; the 6-bit counter never overflows past 63 in RUN.

Optional Feature:
- Macro: SHA256_SCHED_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit, synchronous, active high).
  - abort=1 in any state: next cycle state=IDLE; wt_valid=0; counters 0; done not pulsed.
  - abort takes priority over simultaneous in or wt handshakes; those beats are discarded.
- Undefined: no abort port; only rst_n terminates a block.

Test Plan:
- Message "abc": in_word stream 0x61626380, then 14×0x00000000, then 0x00000018, wt_ready=1 -> W[0]=0x61626380, W[15]=0x00000018, W[16]=0x61626380, W[17]=0x000F0000. Exactly 64 wt_valid beats with wt_idx 0..63, done one pulse, then in_ready=1.
- Random block with random wt_ready backpressure (~50%) -> wt sequence identical to the stall-free run. wt and wt_idx stable while wt_valid&&!wt_ready.
- in_valid gaps during LOAD, plus in_valid=1 held during RUN -> only the first 16 beats are accepted; in_ready=0 throughout RUN; schedule unchanged.
- Two back-to-back blocks with in_valid continuously high -> second block's first beat is accepted the cycle after done; both schedules match the reference model.
- rst_n pulsed low at t=30 -> wt_valid=0 and busy=0 immediately. A fresh block then produces a correct W[0..63].
- With SHA256_SCHED_ABORT_EN: abort at wt_idx=20 while wt_ready=0 -> IDLE next cycle, no done pulse, no further wt_valid; the next block is correct.

Source files
------------

// File: rtl/sha256_msg_sched.sv
// ----------------------------------------------------------------------------
// sha256_msg_sched
//
// SHA-256 message-schedule sequencer. It accepts one 512-bit block as 16
// big-endian 32-bit words, M[0] first. It then emits the 64 schedule words
// W[0..63] in order, one per cycle whenever the consumer is not stalling.
// A 16-entry circular buffer holds the sliding window of schedule words.
// Once t >= 16, W[t] overwrites the slot that held W[t-16].
//
// Ports:
//   clk       in   1   single clock, all state on the rising edge
//   rst_n     in   1   asynchronous active-low reset
//   abort     in   1   synchronous abort (present only with SHA256_SCHED_ABORT_EN)
//   in_valid  in   1   in_word valid
//   in_ready  out  1   a block word can be accepted this cycle
//   in_word   in   32  message word
//   wt_valid  out  1   wt holds a valid schedule word
//   wt_ready  in   1   consumer accepts wt
//   wt        out  32  schedule word W[t]
//   wt_idx    out  6   t of the word on wt
//   busy      out  1   high while loading or running
//   done      out  1   one-cycle pulse after the W[63] handshake
//
// Configuration macro:
//   SHA256_SCHED_ABORT_EN  adds the abort input. When abort is high, the block
//                          returns to idle on the next clock edge and discards
//                          any handshakes in the same cycle. No done pulse is
//                          produced.
// ----------------------------------------------------------------------------
module sha256_msg_sched (
    input  logic        clk,
    input  logic        rst_n,
`ifdef SHA256_SCHED_ABORT_EN
    input  logic        abort,
`endif
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
    output logic        wt_valid,
    input  logic        wt_ready,
    output logic [31:0] wt,
    output logic [5:0]  wt_idx,
    output logic        busy,
    output logic        done
);

    // Fixed by the algorithm; not meant to be overridden.
    localparam int unsigned WORDS     = 16;
    localparam int unsigned ROUNDS    = 64;
    localparam logic [5:0]  LAST_T    = 6'(ROUNDS - 1);
    localparam logic [3:0]  LAST_LOAD = 4'(WORDS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    // ------------------------------------------------------------------------
    // Sigma functions
    // ------------------------------------------------------------------------
    function automatic logic [31:0] f_sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] f_sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]  r_state,    w_state_d;
    logic [3:0]  r_count,    w_count_d;
    logic [5:0]  r_t,        w_t_d;
    logic        r_fin,      w_fin_d;     // all 64 words computed; hold t at 63
    logic        r_in_ready, w_in_ready_d;
    logic        r_wt_valid, w_wt_valid_d;
    logic [31:0] r_wt,       w_wt_d;
    logic [5:0]  r_wt_idx,   w_wt_idx_d;
    logic        r_done,     w_done_d;
    logic [31:0] r_buf [WORDS];

    logic        w_abort;
    logic        w_in_beat;
    logic        w_out_beat;
    logic        w_last_in_beat;
    logic        w_load;
    logic        w_early;
    logic [3:0]  w_slot;
    logic [31:0] w_sched;
    logic [31:0] w_next_word;
    logic        w_buf_we;
    logic [3:0]  w_buf_waddr;
    logic [31:0] w_buf_wdata;

`ifdef SHA256_SCHED_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    // Slot offsets use 4-bit arithmetic, so they wrap modulo 16.
    // (t-15) mod 16 equals (t+1) mod 16.
    assign w_slot  = r_t[3:0];
    assign w_early = (r_t[5:4] == 2'b00);
    assign w_sched = f_sigma1(r_buf[w_slot - 4'd2]) + r_buf[w_slot - 4'd7]
                   + f_sigma0(r_buf[w_slot + 4'd1]) + r_buf[w_slot];
    assign w_next_word = w_early ? r_buf[w_slot] : w_sched;

    // ------------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------------
    // in_ready is low in RUN, so in_valid in RUN never produces a beat.
    assign w_in_beat      = in_valid && r_in_ready;
    assign w_out_beat     = r_wt_valid && wt_ready;
    assign w_last_in_beat = w_in_beat && (r_state == S_LOAD) && (r_count == LAST_LOAD);

    // W[0] is loaded on the final input beat, so wt_valid rises the cycle after
    // it. buf[0] was written on an earlier beat, so it is already available.
    assign w_load = w_last_in_beat
                 || ((r_state == S_RUN) && !r_fin && (!r_wt_valid || wt_ready));

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_d    = r_state;
        w_count_d    = r_count;
        w_t_d        = r_t;
        w_fin_d      = r_fin;
        w_wt_valid_d = r_wt_valid;
        w_wt_d       = r_wt;
        w_wt_idx_d   = r_wt_idx;
        w_done_d     = 1'b0;
        w_buf_we     = 1'b0;
        w_buf_waddr  = r_count;
        w_buf_wdata  = in_word;

        case (r_state)
            S_IDLE: begin
                if (w_in_beat) begin
                    w_buf_we  = 1'b1;
                    w_count_d = r_count + 4'd1;
                    w_state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_in_beat) begin
                    w_buf_we = 1'b1;
                    if (r_count == LAST_LOAD) begin
                        w_count_d = 4'd0;
                        w_state_d = S_RUN;
                    end else begin
                        w_count_d = r_count + 4'd1;
                    end
                end
            end
            S_RUN: begin
                // Once r_fin is set, wt already holds W[63].
                // Its handshake ends the block.
                if (w_out_beat && r_fin && (r_wt_idx == LAST_T)) begin
                    w_wt_valid_d = 1'b0;
                    w_done_d     = 1'b1;
                    w_t_d        = 6'd0;
                    w_fin_d      = 1'b0;
                    w_state_d    = S_IDLE;
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase

        if (w_load) begin
            w_wt_d       = w_next_word;
            w_wt_idx_d   = r_t;
            w_wt_valid_d = 1'b1;
            if (r_t == LAST_T) begin
                w_fin_d = 1'b1;
            end else begin
                w_t_d = r_t + 6'd1;
            end
            // The schedule word replaces the oldest entry in the window.
            if (!w_early) begin
                w_buf_we    = 1'b1;
                w_buf_waddr = w_slot;
                w_buf_wdata = w_sched;
            end
        end

        if (w_abort) begin
            w_state_d    = S_IDLE;
            w_count_d    = 4'd0;
            w_t_d        = 6'd0;
            w_fin_d      = 1'b0;
            w_wt_valid_d = 1'b0;
            w_done_d     = 1'b0;
            w_buf_we     = 1'b0;
        end

        // in_ready is registered and stays low during the done cycle.
        // The next block therefore starts the cycle after done.
        w_in_ready_d = (w_state_d == S_LOAD) || ((w_state_d == S_IDLE) && !w_done_d);
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_count    <= 4'd0;
            r_t        <= 6'd0;
            r_fin      <= 1'b0;
            r_in_ready <= 1'b0;
            r_wt_valid <= 1'b0;
            r_wt       <= 32'd0;
            r_wt_idx   <= 6'd0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_count    <= w_count_d;
            r_t        <= w_t_d;
            r_fin      <= w_fin_d;
            r_in_ready <= w_in_ready_d;
            r_wt_valid <= w_wt_valid_d;
            r_wt       <= w_wt_d;
            r_wt_idx   <= w_wt_idx_d;
            r_done     <= w_done_d;
        end
    end

    // Buffer contents are don't-care after reset, so the buffer needs no reset.
    always_ff @(posedge clk) begin
        if (w_buf_we) begin
            r_buf[w_buf_waddr] <= w_buf_wdata;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign in_ready = r_in_ready;
    assign wt_valid = r_wt_valid;
    assign wt       = r_wt;
    assign wt_idx   = r_wt_idx;
    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;

endmodule
